// File: rtl/spi_adc.sv
// SPI master for a dual-channel 14-bit serial ADC using a 34-bit serial frame.
// It drives the conversion strobe and spi_sck, samples adc_out and presents both channel words.
module spi_adc #(
  parameter int SCK_HALF = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        conv,
  input  logic        adc_out,
  output logic        ad_conv,
  output logic        spi_sck,
  output logic        end_conv,
  output logic [13:0] ch0_out,
  output logic [13:0] ch1_out
);

  localparam int DW = $clog2(2 * SCK_HALF);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * SCK_HALF - 1);
  localparam logic [DW-1:0] DIV_MID  = DW'(SCK_HALF);

  typedef enum logic [1:0] {IDLE, STROBE, SHIFT, DONE} state_t;

  state_t        r_state;
  logic [DW-1:0] r_div;
  logic [5:0]    r_bit;
  logic [33:0]   r_shift;
  logic          r_ad_conv;
  logic          r_sck;
  logic          r_end_conv;
  logic [13:0]   r_ch0;
  logic [13:0]   r_ch1;

  assign ad_conv  = r_ad_conv;
  assign spi_sck  = r_sck;
  assign end_conv = r_end_conv;
  assign ch0_out  = r_ch0;
  assign ch1_out  = r_ch1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_div      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_ad_conv  <= 1'b0;
      r_sck      <= 1'b0;
      r_end_conv <= 1'b0;
      r_ch0      <= '0;
      r_ch1      <= '0;
    end else begin
      r_end_conv <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ad_conv <= 1'b0;
          r_sck     <= 1'b0;
          r_div     <= '0;
          if (conv) begin
            r_state <= STROBE;
          end
        end
        STROBE: begin
          r_ad_conv <= 1'b1;
          if (r_div == DIV_LAST) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_state <= SHIFT;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        SHIFT: begin
          r_ad_conv <= 1'b0;
          r_sck     <= (r_div >= DIV_MID);
          // Sample on the same edge that raises spi_sck; bit 0 ends up in r_shift[33].
          if (r_div == DIV_MID) begin
            r_shift <= {r_shift[32:0], adc_out};
          end
          if (r_div == DIV_LAST) begin
            r_div <= '0;
            if (r_bit == 6'd33) begin
              r_state <= DONE;
            end else begin
              r_bit <= r_bit + 6'd1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        DONE: begin
          r_sck      <= 1'b0;
          r_ch0      <= r_shift[31:18];
          r_ch1      <= r_shift[15:2];
          r_end_conv <= 1'b1;
          r_state    <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc.sv
// Directed bench for spi_adc: frame timing, capture windows, abort and divider, at H=1 and H=3.
`timescale 1ns/1ps
module tb_spi_adc;

  logic        clk;
  logic        reset;
  logic        conv;
  logic        adc_out;
  logic        sel;
  logic        w_ad1, w_sck1, w_ec1, w_ad3, w_sck3, w_ec3;
  logic [13:0] w_c0_1, w_c1_1, w_c0_3, w_c1_3;
  logic        w_ad, w_sck, w_ec;
  logic [13:0] w_c0, w_c1;
  int          n_cmp = 0;
  int          n_err = 0;

  spi_adc #(.SCK_HALF(1)) dut1 (
    .clk(clk), .reset(reset), .conv(conv), .adc_out(adc_out),
    .ad_conv(w_ad1), .spi_sck(w_sck1), .end_conv(w_ec1),
    .ch0_out(w_c0_1), .ch1_out(w_c1_1)
  );

  spi_adc #(.SCK_HALF(3)) dut3 (
    .clk(clk), .reset(reset), .conv(conv), .adc_out(adc_out),
    .ad_conv(w_ad3), .spi_sck(w_sck3), .end_conv(w_ec3),
    .ch0_out(w_c0_3), .ch1_out(w_c1_3)
  );

  assign w_ad  = sel ? w_ad3  : w_ad1;
  assign w_sck = sel ? w_sck3 : w_sck1;
  assign w_ec  = sel ? w_ec3  : w_ec1;
  assign w_c0  = sel ? w_c0_3 : w_c0_1;
  assign w_c1  = sel ? w_c1_3 : w_c1_1;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Value on adc_out for clk edge j of a frame; mode 0 ones, 1 flip at 720 ns, 2 pattern, 3 zeros.
  function automatic logic adc_val(input int mode, input int h, input int j);
    int   b;
    logic v;
    v = 1'b0;
    b = (j >= 2 * h + 1) ? (j - 2 * h - 1) / (2 * h) : -1;
    case (mode)
      0: v = 1'b1;
      1: v = (j <= 35);
      2: begin
        if (b >= 2 && b <= 15)       v = (b % 2 == 0);
        else if (b >= 18 && b <= 31) v = (b % 2 == 1);
        else if (b == 16 || b == 17) v = 1'b1;
        else                         v = 1'b0;
      end
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // Runs one frame starting at the next clk edge (cycle 0) and checks timing and results.
  task automatic run_frame(input bit use3, input int h, input int mode,
                           input logic [13:0] pe0, input logic [13:0] pe1,
                           input logic [13:0] e0, input logic [13:0] e1, input string tag);
    int   n_ad, ad_first, n_rise, rise_first, n_hi, n_ec, ec_cyc, n_ovl, n_chg;
    logic prev_s;
    n_ad = 0; ad_first = -1; n_rise = 0; rise_first = -1; n_hi = 0;
    n_ec = 0; ec_cyc = -1; n_ovl = 0; n_chg = 0; prev_s = 1'b0;
    sel     = use3;
    conv    = 1'b1;
    adc_out = adc_val(mode, h, 0);
    for (int k = 0; k <= 70 * h + 1; k++) begin
      @(negedge clk);
      if (w_ad) begin
        n_ad++;
        if (ad_first < 0) ad_first = k;
      end
      if (w_sck && !prev_s) begin
        n_rise++;
        if (rise_first < 0) rise_first = k;
      end
      if (w_sck) n_hi++;
      if (w_ad && w_sck) n_ovl++;
      if (w_ec) begin
        n_ec++;
        if (ec_cyc < 0) ec_cyc = k;
      end else if (w_c0 !== pe0 || w_c1 !== pe1) begin
        n_chg++;
      end
      prev_s  = w_sck;
      adc_out = adc_val(mode, h, k + 1);
    end
    check({tag, "/ad_first"},   ad_first,   1);
    check({tag, "/ad_len"},     n_ad,       2 * h);
    check({tag, "/sck_first"},  rise_first, 3 * h + 1);
    check({tag, "/sck_rises"},  n_rise,     34);
    check({tag, "/sck_high"},   n_hi,       34 * h);
    check({tag, "/overlap"},    n_ovl,      0);
    check({tag, "/ec_cycle"},   ec_cyc,     70 * h + 1);
    check({tag, "/ec_len"},     n_ec,       1);
    check({tag, "/hold"},       n_chg,      0);
    check({tag, "/ch0"},        w_c0,       e0);
    check({tag, "/ch1"},        w_c1,       e1);
    $display("frame %s: H=%0d end_conv@%0d ch0=%h ch1=%h", tag, h, ec_cyc, w_c0, w_c1);
  endtask

  task automatic idle_gap();
    conv = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n_bad;
    sel = 1'b0; reset = 1'b0; conv = 1'b1; adc_out = 1'b1;
    n_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (w_sck1 || w_ad1 || w_ec1 || w_sck3 || w_ad3 || w_ec3) n_bad++;
    end
    check("rst/activity", n_bad, 0);
    check("rst/ch0", w_c0_1, 14'h0);
    check("rst/ch1", w_c1_1, 14'h0);
    check("rst/ch0_h3", w_c0_3, 14'h0);
    $display("reset held 10 cycles, activity=%0d", n_bad);
    reset = 1'b1;

    run_frame(1'b0, 1, 0, 14'h0000, 14'h0000, 14'h3FFF, 14'h3FFF, "ones");
    idle_gap();
    run_frame(1'b0, 1, 1, 14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h0000, "flip1");
    run_frame(1'b0, 1, 3, 14'h3FFF, 14'h0000, 14'h0000, 14'h0000, "flip2");
    idle_gap();
    run_frame(1'b0, 1, 2, 14'h0000, 14'h0000, 14'h2AAA, 14'h1555, "pattern");
    idle_gap();

    // Abort during bit 10 (cycles 23..24 at H=1) while old results are still held.
    sel = 1'b0;
    conv = 1'b1;
    adc_out = 1'b1;
    repeat (24) @(negedge clk);
    check("abort/pre_ch0", w_c0_1, 14'h2AAA);
    check("abort/pre_ch1", w_c1_1, 14'h1555);
    reset = 1'b0;
    #1;
    check("abort/ch0", w_c0_1, 14'h0);
    check("abort/ch1", w_c1_1, 14'h0);
    check("abort/sig", {w_ad1, w_sck1, w_ec1}, 3'b000);
    conv = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    n_bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (w_sck1 || w_ad1 || w_ec1 || w_sck3 || w_ad3 || w_ec3) n_bad++;
    end
    check("abort/idle", n_bad, 0);
    check("abort/ch0_after", w_c0_1, 14'h0);
    $display("abort at bit 10, post-release activity=%0d", n_bad);

    run_frame(1'b1, 3, 0, 14'h0000, 14'h0000, 14'h3FFF, 14'h3FFF, "div3");
    conv = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
